mips_write_monitor: RTL and testbench
=====================================

# mips_write_monitor

Synthesisable self-checking monitor for the pipelined MIPS data-memory write port. It watches `memwrite`/`dataadr`/`writedata`, compares each write against an ordered queue of expected (address, data) pairs, and reports pass, mismatch, unexpected write or watchdog timeout. It sits beside `top` in simulation and in FPGA bring-up builds. It generalises the single-address "write 5 to 84" check to a loadable sequence, an ignore window and a timeout.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `DEPTH`, 8, expected-write queue depth; power of two, ≥2
- `IGN_BASE`, 80, byte address of first ignored word
- `IGN_WORDS`, 1, number of consecutive ignored words (0 disables the window)
- `TIMEOUT`, 4096, watchdog limit in cycles
- `clk  in  1  clock; all state updates on rising edge`
- `reset  in  1  asynchronous, active-low reset`
- `clear  in  1  synchronous flush; returns to IDLE`
- `start  in  1  IDLE→RUN pulse`
- `exp_valid  in  1  expected-entry push request`
- `exp_ready  out  1  queue can accept an entry`
- `exp_addr  in  AW  expected address`
- `exp_data  in  DW  expected data`
- `exp_last  in  1  entry is the final one of the sequence`
- `memwrite  in  1  DUT data-memory write enable`
- `dataadr  in  AW  DUT write address`
- `writedata  in  DW  DUT write data`
- `busy  out  1  state == RUN`
- `done  out  1  terminal state reached`
- `pass  out  1  sequence completed without error`
- `fail_code  out  2  0 none, 1 mismatch, 2 unexpected, 3 timeout`
- `match_cnt  out  16  matched writes since start, saturating`
- `fail_addr  out  AW  address of the offending write`
- `fail_data  out  DW  data of the offending write`

## Operation
- Queue is a FIFO of {addr, data, last}. A push occurs when `exp_valid && exp_ready`. `exp_ready = (count < DEPTH) && state ∈ {IDLE, RUN}`; it depends on count only, so a same-cycle pop does not raise it.
- States are IDLE, RUN, PASS, FAIL. TIMEOUT is encoded as FAIL with `fail_code = 3`.
- IDLE: pushes are accepted and `memwrite` is ignored. `start` moves the block to RUN and clears `match_cnt` and the watchdog.
- RUN, on each cycle with `memwrite = 1`:
  - Address in `[IGN_BASE, IGN_BASE + 4*IGN_WORDS)`: no effect.
  - Queue empty: FAIL, `fail_code = 2`.
  - Address and data equal to the head: pop, `match_cnt++`, watchdog cleared. If the head's `last` bit is set, go to PASS.
  - Otherwise: FAIL, `fail_code = 1`.
  - On any failure, `fail_addr` and `fail_data` capture the offending bus values.
- Watchdog counts RUN cycles since start or since the last match. When it reaches `TIMEOUT - 1` with no match in that cycle, go to FAIL with `fail_code = 3`. A match in the same cycle wins.
- PASS and FAIL are sticky. `start` is ignored there; only `clear` or `reset` leaves them.
- `clear` has priority over `start` and over pushes. It empties the queue and zeroes all status.
- In PASS, `pass = 1` and `done = 1`. In FAIL, `pass = 0` and `done = 1`.

## Timing
- Reset (asynchronous, immediate): state IDLE, queue empty, `busy = done = pass = 0`, `fail_code = 0`, `match_cnt = 0`, `fail_addr = fail_data = 0`. `exp_ready = 1`.
- All status outputs are registered. They update on the rising edge that samples the deciding write, so they are visible one cycle after the write is presented.
- Push and pop in the same cycle are legal. Count is unchanged and the push is appended behind the remaining entries.
- Pointers wrap modulo `DEPTH`. Full/empty are distinguished by a count of width `log2(DEPTH) + 1`.
- Reset asserted mid-RUN aborts immediately with no partial status retained.

## Configuration
- `WMON_WATCHDOG_EN` defined: the watchdog counter and `fail_code = 3` exist as described.
- `WMON_WATCHDOG_EN` undefined: no counter is built, RUN waits indefinitely, and `fail_code` never takes the value 3.

## Test plan
- Push (84, 5, last); start; write (80, 7) then (84, 5) → the cycle after: `pass = 1`, `done = 1`, `fail_code = 0`, `match_cnt = 1`.
- Push (84, 5, last); start; write (88, 5) → `fail_code = 1`, `fail_addr = 88`, `fail_data = 5`, `pass = 0`.
- Push 8 entries → `exp_ready = 0`; a 9th push is held. Start, match one → `exp_ready = 1`. The held entry enters, and the sequence later passes with `match_cnt = 9`.
- Empty queue, start, write (84, 5) → `fail_code = 2`, `done = 1`.
- `TIMEOUT = 16`, push one entry, start, no writes → `fail_code = 3` exactly 16 cycles after start. Without `WMON_WATCHDOG_EN`: still `busy = 1` after 100 cycles.
- Drop `reset` mid-RUN, between clock edges → all outputs 0 immediately and `exp_ready = 1`. After release, a fresh sequence passes.

Source files
------------

// File: rtl/mips_write_monitor.sv
// mips_write_monitor: self-checking monitor for the MIPS data-memory write port.
// Each observed write is compared against an ordered FIFO of expected
// (address, data, last) entries, and the block reports pass, mismatch,
// unexpected write or watchdog timeout through registered status outputs.
// Writes inside [IGN_BASE, IGN_BASE + 4*IGN_WORDS) are ignored.
// Optional feature macro: WMON_WATCHDOG_EN builds the no-match watchdog
// (fail_code 3); without it RUN waits indefinitely.
module mips_write_monitor #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int DEPTH     = 8,
  parameter int IGN_BASE  = 80,
  parameter int IGN_WORDS = 1,
  parameter int TIMEOUT   = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          start,
  input  logic          exp_valid,
  output logic          exp_ready,
  input  logic [AW-1:0] exp_addr,
  input  logic [DW-1:0] exp_data,
  input  logic          exp_last,
  input  logic          memwrite,
  input  logic [AW-1:0] dataadr,
  input  logic [DW-1:0] writedata,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [1:0]    fail_code,
  output logic [15:0]   match_cnt,
  output logic [AW-1:0] fail_addr,
  output logic [DW-1:0] fail_data
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [AW:0] IGN_LO = (AW+1)'(IGN_BASE);
  localparam logic [AW:0] IGN_HI = (AW+1)'(IGN_BASE + 4 * IGN_WORDS);

  // Elaboration-time parameter sanity checks.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("TIMEOUT must be at least 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t          state, state_next;
  logic [AW-1:0]   q_addr [DEPTH];
  logic [DW-1:0]   q_data [DEPTH];
  logic            q_last [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  logic            push, pop, in_window, head_match, wdog_expired;
  logic [1:0]      fail_code_next;
  logic [15:0]     match_cnt_next;
  logic [AW-1:0]   fail_addr_next;
  logic [DW-1:0]   fail_data_next;

  assign exp_ready  = (count < (PW+1)'(DEPTH)) && (state == S_IDLE || state == S_RUN);
  assign push       = exp_valid && exp_ready && !clear;
  assign in_window  = ({1'b0, dataadr} >= IGN_LO) && ({1'b0, dataadr} < IGN_HI);
  assign head_match = (dataadr == q_addr[rd_ptr]) && (writedata == q_data[rd_ptr]);

  assign busy = (state == S_RUN);
  assign done = (state == S_PASS) || (state == S_FAIL);
  assign pass = (state == S_PASS);

`ifdef WMON_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT);
  logic [WW-1:0] wdog;

  // Watchdog: counts RUN cycles since start or since the last match.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                            wdog <= '0;
    else if (clear || pop || state != S_RUN) wdog <= '0;
    else                                   wdog <= wdog + WW'(1);
  end

  assign wdog_expired = (state == S_RUN) && (wdog == WW'(TIMEOUT - 1));
`else
  assign wdog_expired = 1'b0;
`endif

  // Next-state and status decision for the current cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next     = state;
    fail_code_next = fail_code;
    match_cnt_next = match_cnt;
    fail_addr_next = fail_addr;
    fail_data_next = fail_data;
    pop            = 1'b0;
    if (clear) begin
      state_next     = S_IDLE;
      fail_code_next = 2'd0;
      match_cnt_next = '0;
      fail_addr_next = '0;
      fail_data_next = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_next     = S_RUN;
            match_cnt_next = '0;
          end
        end
        S_RUN: begin
          if (memwrite && !in_window) begin
            if (count == '0) begin
              state_next     = S_FAIL;
              fail_code_next = 2'd2;
              fail_addr_next = dataadr;
              fail_data_next = writedata;
            end else if (head_match) begin
              pop = 1'b1;
              if (match_cnt != 16'hFFFF) match_cnt_next = match_cnt + 16'd1;
              if (q_last[rd_ptr]) state_next = S_PASS;
            end else begin
              state_next     = S_FAIL;
              fail_code_next = 2'd1;
              fail_addr_next = dataadr;
              fail_data_next = writedata;
            end
          end else if (wdog_expired) begin
            state_next     = S_FAIL;
            fail_code_next = 2'd3;
          end
        end
        default: ;
      endcase
    end
  end

  // State and status registers.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset) begin
      state     <= S_IDLE;
      fail_code <= 2'd0;
      match_cnt <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      state     <= state_next;
      fail_code <= fail_code_next;
      match_cnt <= match_cnt_next;
      fail_addr <= fail_addr_next;
      fail_data <= fail_data_next;
    end
  end

  // FIFO pointers and occupancy; clear flushes the queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + (PW+1)'(1);
      else if (pop && !push) count <= count - (PW+1)'(1);
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; entries are only read when count says they are valid.
    if (push) begin
      q_addr[wr_ptr] <= exp_addr;
      q_data[wr_ptr] <= exp_data;
      q_last[wr_ptr] <= exp_last;
    end
  end

endmodule

// File: tb/tb_mips_write_monitor.sv
// Testbench for mips_write_monitor: table-driven single-write vectors with a
// scoreboard queue, plus hand-written multi-cycle sequences (queue full,
// empty-queue write, watchdog, sticky terminal states, mid-run reset).
module tb_mips_write_monitor;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clear = 1'b0, start = 1'b0;
  logic          exp_valid = 1'b0, exp_last = 1'b0;
  logic          exp_ready;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_data = '0;
  logic          memwrite = 1'b0;
  logic [AW-1:0] dataadr = '0;
  logic [DW-1:0] writedata = '0;
  logic          busy, done, pass;
  logic [1:0]    fail_code;
  logic [15:0]   match_cnt;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;

  int tests  = 0;
  int errors = 0;

  mips_write_monitor #(
    .AW(AW), .DW(DW), .DEPTH(8), .IGN_BASE(80), .IGN_WORDS(1), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .start(start),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_addr(exp_addr),
    .exp_data(exp_data), .exp_last(exp_last), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata), .busy(busy), .done(done),
    .pass(pass), .fail_code(fail_code), .match_cnt(match_cnt),
    .fail_addr(fail_addr), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        busy, done, pass;
    logic [1:0]  code;
    logic [15:0] cnt;
    logic [31:0] fa, fd;
  } res_t;

  typedef struct {
    logic [31:0] e_addr, e_data, w_addr, w_data;
    res_t        res;
  } vec_t;

  res_t sb[$];
  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pop the oldest expected result and compare it against the DUT status.
  task automatic sb_check(input string tag);
    res_t r;
    if (sb.size() == 0) begin
      check({tag, " sb_empty"}, 64'd1, 64'd0);
    end else begin
      r = sb.pop_front();
      check({tag, " busy"},      busy,      r.busy);
      check({tag, " done"},      done,      r.done);
      check({tag, " pass"},      pass,      r.pass);
      check({tag, " fail_code"}, fail_code, r.code);
      check({tag, " match_cnt"}, match_cnt, r.cnt);
      check({tag, " fail_addr"}, fail_addr, r.fa);
      check({tag, " fail_data"}, fail_data, r.fd);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_entry(input logic [31:0] a, input logic [31:0] d, input logic l);
    exp_valid = 1'b1; exp_addr = a; exp_data = d; exp_last = l;
    tick();
    exp_valid = 1'b0; exp_last = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    tick();
    memwrite = 1'b0;
  endtask

  function automatic res_t mk(input logic b, input logic dn, input logic p, input logic [1:0] c,
                              input logic [15:0] n, input logic [31:0] fa, input logic [31:0] fd);
    res_t r;
    r.busy = b; r.done = dn; r.pass = p; r.code = c; r.cnt = n; r.fa = fa; r.fd = fd;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Single-write vectors: one expected entry (last), start, one write.
    vecs[0] = '{32'd84,  32'd5,       32'd84,  32'd5,       mk(0, 1, 1, 2'd0, 16'd1, 32'd0,  32'd0)};
    vecs[1] = '{32'd84,  32'd5,       32'd88,  32'd5,       mk(0, 1, 0, 2'd1, 16'd0, 32'd88, 32'd5)};
    vecs[2] = '{32'd84,  32'd5,       32'd84,  32'd6,       mk(0, 1, 0, 2'd1, 16'd0, 32'd84, 32'd6)};
    vecs[3] = '{32'd100, 32'hdeadbeef, 32'd100, 32'hdeadbeef, mk(0, 1, 1, 2'd0, 16'd1, 32'd0, 32'd0)};
    vecs[4] = '{32'd84,  32'd5,       32'd79,  32'd5,       mk(0, 1, 0, 2'd1, 16'd0, 32'd79, 32'd5)};
    vecs[5] = '{32'd84,  32'd5,       32'd83,  32'd9,       mk(1, 0, 0, 2'd0, 16'd0, 32'd0,  32'd0)};
    vecs[6] = '{32'd84,  32'd5,       32'd80,  32'd5,       mk(1, 0, 0, 2'd0, 16'd0, 32'd0,  32'd0)};
    vecs[7] = '{32'd84,  32'd5,       32'd0,   32'd5,       mk(0, 1, 0, 2'd1, 16'd0, 32'd0,  32'd5)};

    // Reset state.
    #12;
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst pass", pass, 1'b0);
    check("rst fail_code", fail_code, 2'd0);
    check("rst match_cnt", match_cnt, 16'd0);
    check("rst fail_addr", fail_addr, 32'd0);
    check("rst fail_data", fail_data, 32'd0);
    check("rst exp_ready", exp_ready, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Table-driven vectors.
    for (int i = 0; i < 8; i++) begin
      do_clear();
      push_entry(vecs[i].e_addr, vecs[i].e_data, 1'b1);
      do_start();
      sb.push_back(vecs[i].res);
      do_write(vecs[i].w_addr, vecs[i].w_data);
      sb_check($sformatf("vec%0d", i));
    end

    // Ignored write then match.
    do_clear();
    push_entry(32'd84, 32'd5, 1'b1);
    do_start();
    sb.push_back(mk(1, 0, 0, 2'd0, 16'd0, 32'd0, 32'd0));
    do_write(32'd80, 32'd7);
    sb_check("ign_then");
    sb.push_back(mk(0, 1, 1, 2'd0, 16'd1, 32'd0, 32'd0));
    do_write(32'd84, 32'd5);
    sb_check("match84");

    // Full queue: 8 entries, 9th held until a pop frees a slot.
    do_clear();
    for (int i = 0; i < 8; i++) push_entry(32'd200 + 32'(4 * i), 32'(i + 1), 1'b0);
    check("full exp_ready", exp_ready, 1'b0);
    exp_valid = 1'b1; exp_addr = 32'd232; exp_data = 32'd9; exp_last = 1'b1;
    tick();
    check("held exp_ready", exp_ready, 1'b0);
    do_start();
    check("full busy", busy, 1'b1);
    do_write(32'd200, 32'd1);
    check("after pop exp_ready", exp_ready, 1'b1);
    check("after pop match_cnt", match_cnt, 16'd1);
    tick();
    exp_valid = 1'b0; exp_last = 1'b0;
    for (int i = 1; i < 9; i++) do_write(32'd200 + 32'(4 * i), 32'(i + 1));
    sb.push_back(mk(0, 1, 1, 2'd0, 16'd9, 32'd0, 32'd0));
    sb_check("full seq");

    // Same-cycle push and pop keeps order: entries A, B then C pushed while A pops.
    do_clear();
    push_entry(32'd300, 32'd1, 1'b0);
    push_entry(32'd304, 32'd2, 1'b0);
    do_start();
    exp_valid = 1'b1; exp_addr = 32'd308; exp_data = 32'd3; exp_last = 1'b1;
    do_write(32'd300, 32'd1);
    exp_valid = 1'b0; exp_last = 1'b0;
    do_write(32'd304, 32'd2);
    check("pp mid busy", busy, 1'b1);
    do_write(32'd308, 32'd3);
    sb.push_back(mk(0, 1, 1, 2'd0, 16'd3, 32'd0, 32'd0));
    sb_check("push_pop");

    // Empty queue write is unexpected; FAIL is sticky against start and writes.
    do_clear();
    do_start();
    sb.push_back(mk(0, 1, 0, 2'd2, 16'd0, 32'd84, 32'd5));
    do_write(32'd84, 32'd5);
    sb_check("unexpected");
    do_start();
    sb.push_back(mk(0, 1, 0, 2'd2, 16'd0, 32'd84, 32'd5));
    do_write(32'd90, 32'd1);
    sb_check("sticky");

    // Clear wins over start in the same cycle.
    clear = 1'b1; start = 1'b1;
    tick();
    clear = 1'b0; start = 1'b0;
    check("clr_start busy", busy, 1'b0);
    check("clr_start done", done, 1'b0);
    check("clr_start fail_code", fail_code, 2'd0);

    // Watchdog.
    push_entry(32'd84, 32'd5, 1'b1);
    do_start();
`ifdef WMON_WATCHDOG_EN
    for (int i = 0; i < 15; i++) tick();
    check("wd pre busy", busy, 1'b1);
    check("wd pre fail_code", fail_code, 2'd0);
    tick();
    check("wd fail_code", fail_code, 2'd3);
    check("wd done", done, 1'b1);
    check("wd busy", busy, 1'b0);
`else
    for (int i = 0; i < 100; i++) tick();
    check("nowd busy", busy, 1'b1);
    check("nowd fail_code", fail_code, 2'd0);
`endif

    // Reset mid-RUN between clock edges.
    do_clear();
    push_entry(32'd84, 32'd5, 1'b0);
    push_entry(32'd88, 32'd6, 1'b1);
    do_start();
    do_write(32'd84, 32'd5);
    check("pre_rst match_cnt", match_cnt, 16'd1);
    #3;
    reset = 1'b0;
    #1;
    check("mid_rst busy", busy, 1'b0);
    check("mid_rst match_cnt", match_cnt, 16'd0);
    check("mid_rst exp_ready", exp_ready, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    tick();
    push_entry(32'd84, 32'd5, 1'b1);
    do_start();
    sb.push_back(mk(0, 1, 1, 2'd0, 16'd1, 32'd0, 32'd0));
    do_write(32'd84, 32'd5);
    sb_check("post_rst");

    check("sb drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
